// File: rtl/adc_cfg_seq.sv
// adc_cfg_seq: power-up configuration sequencer for the LVDS ADC front end.
// Writes a table of 24-bit registers over 3-wire SPI, enables the
// deserializer, then waits for frame alignment with a timeout.
//
// Ports:
//   CLKDIV, cpu_resetn        clock, asynchronous active-low reset
//   start                     one-cycle request to (re)run the sequence
//   cfg_idx / cfg_word        table index out, table entry in
//   aligned                   bitslip frame alignment flag
//   spi_csn/spi_sclk/spi_sdio SPI master, mode 0, MSB first
//   adc_en, busy, done, error enable and status, all registered
module adc_cfg_seq #(
   parameter int NUM_REGS      = 8,
   parameter int SCLK_HALF     = 4,
   parameter int CS_GAP        = 8,
   parameter int ALIGN_TIMEOUT = 1024,
   parameter bit AUTO_START    = 1'b1,
   localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic          CLKDIV,
   input  logic          cpu_resetn,
   input  logic          start,
   output logic [IW-1:0] cfg_idx,
   input  logic [23:0]   cfg_word,
   input  logic          aligned,
   output logic          spi_csn,
   output logic          spi_sclk,
   output logic          spi_sdio,
   output logic          adc_en,
   output logic          busy,
   output logic          done,
   output logic          error
);

   localparam int CM1 = (SCLK_HALF > CS_GAP) ? SCLK_HALF : CS_GAP;
   localparam int CMAX = (CM1 > ALIGN_TIMEOUT) ? CM1 : ALIGN_TIMEOUT;
   localparam int CW = $clog2(CMAX + 1);

   localparam logic [CW-1:0] HALF_LAST = CW'(SCLK_HALF - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(CS_GAP - 1);
   localparam logic [CW-1:0] TO_LAST   = CW'(ALIGN_TIMEOUT - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_REGS - 1);
   localparam logic [5:0]    PH_LAST   = 6'd48;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_GAP,
      S_ALIGN,
      S_DONE,
      S_FAIL
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [5:0]      phase_q, phase_d;
   logic [23:0]     sr_q, sr_d;
   logic            csn_q, csn_d;
   logic            sclk_q, sclk_d;
   logic            sdio_q, sdio_d;
   logic            adc_en_q, adc_en_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            error_q, error_d;
   logic            go;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      phase_d  = phase_q;
      sr_d     = sr_q;
      adc_en_d = adc_en_q;
      busy_d   = busy_q;
      done_d   = done_q;
      error_d  = error_q;
      go       = 1'b0;

      unique case (state_q)
         S_IDLE: go = AUTO_START || start;
         S_LOAD: begin
            sr_d    = cfg_word;
            phase_d = '0;
            cnt_d   = '0;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               if (phase_q == PH_LAST) begin
                  state_d = S_GAP;
               end else begin
                  phase_d = phase_q + 6'd1;
                  // next bit is presented as each low phase begins
                  if (phase_q[0]) sr_d = {sr_q[22:0], 1'b0};
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               if (idx_q == IDX_LAST) begin
                  state_d = S_ALIGN;
               end else begin
                  idx_d   = idx_q + IW'(1);
                  state_d = S_LOAD;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_ALIGN: begin
            // first ALIGN cycle registers adc_en; alignment and the
            // timeout window are judged only once the deserializer
            // has actually been released
            if (!adc_en_q) begin
               adc_en_d = 1'b1;
            end else if (aligned) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else if (cnt_q == TO_LAST) begin
               state_d = S_FAIL;
               error_d = 1'b1;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE, S_FAIL: go = start;
         default: state_d = S_IDLE;
      endcase

      if (go) begin
         state_d  = S_LOAD;
         idx_d    = '0;
         adc_en_d = 1'b0;
         busy_d   = 1'b1;
         done_d   = 1'b0;
         error_d  = 1'b0;
      end

      // SPI pins follow the next state so they stay registered
      csn_d  = (state_d != S_SHIFT);
      sclk_d = (state_d == S_SHIFT) && phase_d[0];
      sdio_d = (state_d == S_SHIFT) && (phase_d != PH_LAST) && sr_d[23];
   end

   always_ff @(posedge CLKDIV or negedge cpu_resetn) begin
      if (!cpu_resetn) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         phase_q  <= '0;
         sr_q     <= '0;
         csn_q    <= 1'b1;
         sclk_q   <= 1'b0;
         sdio_q   <= 1'b0;
         adc_en_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         phase_q  <= phase_d;
         sr_q     <= sr_d;
         csn_q    <= csn_d;
         sclk_q   <= sclk_d;
         sdio_q   <= sdio_d;
         adc_en_q <= adc_en_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         error_q  <= error_d;
      end
   end

   assign cfg_idx  = idx_q;
   assign spi_csn  = csn_q;
   assign spi_sclk = sclk_q;
   assign spi_sdio = sdio_q;
   assign adc_en   = adc_en_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign error    = error_q;

endmodule

// File: tb/tb_adc_cfg_seq.sv
// tb_adc_cfg_seq: scoreboard bench for adc_cfg_seq; SPI frames decoded
// by a monitor are compared against a queue of expected table writes.
module tb_adc_cfg_seq;

   localparam int NR   = 3;
   localparam int SH   = 2;
   localparam int GAP  = 4;
   localparam int TO   = 16;
   localparam int FLEN = 49 * SH;
   localparam int RUN  = NR * (FLEN + GAP + 1);

   logic        CLKDIV = 1'b0;
   logic        cpu_resetn = 1'b1;
   logic        start = 1'b0;
   logic        aligned = 1'b0;
   logic [1:0]  cfg_idx;
   logic [23:0] cfg_word;
   logic        spi_csn, spi_sclk, spi_sdio;
   logic        adc_en, busy, done, error;

   logic [23:0] tbl [4];
   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [23:0] word;
      int          idx;
   } exp_t;
   exp_t exp_q[$];

   adc_cfg_seq #(
      .NUM_REGS(NR),
      .SCLK_HALF(SH),
      .CS_GAP(GAP),
      .ALIGN_TIMEOUT(TO),
      .AUTO_START(1'b1)
   ) dut (
      .CLKDIV(CLKDIV),
      .cpu_resetn(cpu_resetn),
      .start(start),
      .cfg_idx(cfg_idx),
      .cfg_word(cfg_word),
      .aligned(aligned),
      .spi_csn(spi_csn),
      .spi_sclk(spi_sclk),
      .spi_sdio(spi_sdio),
      .adc_en(adc_en),
      .busy(busy),
      .done(done),
      .error(error)
   );

   always #5 CLKDIV = ~CLKDIV;

   assign cfg_word = tbl[cfg_idx];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0: return adc_en;
         1: return error;
         2: return done;
         3: return spi_csn;
         4: return spi_sclk;
         default: return 1'bx;
      endcase
   endfunction

   task automatic wait_lvl(input string name, input int sel, input logic lvl,
                           input int budget, output int n);
      n = 0;
      while (sig(sel) !== lvl && n < budget) begin
         @(negedge CLKDIV);
         n++;
      end
      if (sig(sel) !== lvl) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: timed out after %0d cycles, required level %0b",
                  name, n, lvl);
      end
   endtask

   task automatic push_run();
      for (int i = 0; i < NR; i++) begin
         exp_t e;
         e.word = tbl[i];
         e.idx  = i;
         exp_q.push_back(e);
      end
   endtask

   task automatic new_table();
      for (int i = 0; i < NR; i++) tbl[i] = 24'($urandom);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge CLKDIV);
      start = 1'b0;
   endtask

   // SPI monitor: decodes frames and checks them against the queue
   initial begin
      logic        prev_csn, prev_sclk;
      int          flen, edges, hi, gap_seen, fidx;
      logic [23:0] bits;
      exp_t        e;
      prev_csn = 1'b1; prev_sclk = 1'b0;
      flen = 0; edges = 0; hi = 0; gap_seen = 0; fidx = 0; bits = '0;
      forever begin
         @(negedge CLKDIV);
         if (!cpu_resetn) begin
            prev_csn = 1'b1; prev_sclk = 1'b0;
            flen = 0; edges = 0; bits = '0;
         end else begin
            if (!spi_csn) begin
               if (prev_csn) begin
                  gap_seen = hi;
                  flen = 0; edges = 0; bits = '0;
                  fidx = int'(cfg_idx);
               end
               flen++;
               if (spi_sclk && !prev_sclk) begin
                  bits = {bits[22:0], spi_sdio};
                  edges++;
               end
               hi = 0;
            end else begin
               if (!prev_csn) begin
                  if (exp_q.size() == 0) begin
                     n_checks++;
                     n_errors++;
                     $display("FAIL frame_unexpected: got word %06h, required none",
                              bits);
                  end else begin
                     e = exp_q.pop_front();
                     check("frame_word", 32'(bits), 32'(e.word));
                     check("frame_len", flen, FLEN);
                     check("frame_sclk_edges", edges, 24);
                     check("frame_idx", fidx, e.idx);
                     if (e.idx > 0) check("frame_gap", gap_seen, GAP + 1);
                  end
               end
               hi++;
            end
            prev_csn = spi_csn;
            prev_sclk = spi_sclk;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, t, rises;
      logic ps;
      tbl[0] = 24'h0A5C3F;
      tbl[1] = 24'h001403;
      tbl[2] = 24'h00FF01;
      tbl[3] = 24'h000000;

      // reset state
      #1 cpu_resetn = 1'b0;
      repeat (3) @(negedge CLKDIV);
      check("reset_outputs",
            {spi_csn, spi_sclk, spi_sdio, adc_en, busy, done, error, cfg_idx},
            {1'b1, 6'b0, 2'b0});

      // run 1: auto start, aligned tied high
      aligned = 1'b1;
      push_run();
      cpu_resetn = 1'b1;
      wait_lvl("auto_csn_fall", 3, 1'b0, 10, n);
      check("auto_start_latency", n, 2);
      wait_lvl("run1_adc_en", 0, 1'b1, 2 * RUN, n);
      check("run1_length", n, RUN);
      check("run1_last_idx", cfg_idx, NR - 1);
      check("run1_done_before", done, 0);
      @(negedge CLKDIV);
      check("run1_done_after", {done, busy, adc_en, error}, 4'b1010);

      // run 2: timeout, with ignored starts in SHIFT and ALIGN
      aligned = 1'b0;
      new_table();
      push_run();
      pulse_start();
      check("restart_clear", {done, error, adc_en, busy}, 4'b0001);
      wait_lvl("run2_csn_fall", 3, 1'b0, 10, n);
      check("run2_csn_latency", n, 1);
      repeat (20) @(negedge CLKDIV);
      pulse_start();
      t = 21;
      wait_lvl("run2_adc_en", 0, 1'b1, 2 * RUN, n);
      check("run2_length_ign_start", t + n, RUN);
      repeat (3) @(negedge CLKDIV);
      pulse_start();
      wait_lvl("run2_error", 1, 1'b1, 4 * TO, n);
      check("timeout_latency", n + 4, TO);
      check("timeout_flags", {done, busy, adc_en}, 3'b001);
      repeat (3) @(negedge CLKDIV);
      check("error_sticky", {error, adc_en, busy}, 3'b110);

      // run 3: restart from FAIL, align on last counted cycle
      new_table();
      push_run();
      pulse_start();
      check("fail_restart_clear", {error, adc_en, busy}, 3'b001);
      wait_lvl("run3_csn_fall", 3, 1'b0, 10, n);
      check("run3_csn_latency", n, 1);
      wait_lvl("run3_adc_en", 0, 1'b1, 2 * RUN, n);
      repeat (TO - 1) @(negedge CLKDIV);
      check("boundary_pre_error", error, 0);
      aligned = 1'b1;
      @(negedge CLKDIV);
      check("boundary_align", {done, error, busy, adc_en}, 4'b1001);

      // run 4: reset in the middle of frame 1
      new_table();
      push_run();
      pulse_start();
      n = 0;
      while (cfg_idx != 2'd1 && n < 2 * RUN) begin
         @(negedge CLKDIV);
         n++;
      end
      check("reach_frame1", cfg_idx, 1);
      wait_lvl("frame1_csn", 3, 1'b0, 10, n);
      rises = 0;
      n = 0;
      ps = spi_sclk;
      while (rises < 11 && n < FLEN) begin
         @(negedge CLKDIV);
         n++;
         if (spi_sclk && !ps) rises++;
         ps = spi_sclk;
      end
      check("frame1_bit10_reached", rises, 11);
      #2 cpu_resetn = 1'b0;
      #1;
      check("async_reset_outputs",
            {spi_csn, spi_sclk, spi_sdio, adc_en, busy, done, error, cfg_idx},
            {1'b1, 6'b0, 2'b0});
      exp_q.delete();
      new_table();
      push_run();
      repeat (3) @(negedge CLKDIV);
      cpu_resetn = 1'b1;
      wait_lvl("rst_csn_fall", 3, 1'b0, 10, n);
      check("rst_restart_latency", n, 2);
      check("rst_restart_idx", cfg_idx, 0);
      wait_lvl("run4_adc_en", 0, 1'b1, 2 * RUN, n);
      check("run4_length", n, RUN);
      @(negedge CLKDIV);
      check("run4_done", {done, busy, error}, 3'b100);

      repeat (5) @(negedge CLKDIV);
      check("exp_queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
